// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {RUN, MUL_BUSY} ctrl_state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t XZR = 5'd31;

  // A source operand hazards on a destination only if it is really read
  // and the destination is not the zero register.
  function automatic logic src_hazard(input logic uses, input reg_idx_t src,
                                      input reg_idx_t dst);
    return uses && (src == dst) && (dst != XZR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, multiply
// occupancy of EX, taken-branch flushes and load-use bubbles, plus perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rn,
  input  logic [4:0]       ID_Rm,
  input  logic             ID_uses_rn,
  input  logic             ID_uses_rm,
  input  logic             ID_is_mul,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic             EX_branch_taken,
  input  logic             MEM_access,
  input  logic             MEM_ready,
  output logic             PC_write_en,
  output logic             IFID_write_en,
  output logic             IFID_flush,
  output logic             IDEX_write_en,
  output logic             IDEX_bubble,
  output logic             EXMEM_write_en,
  output logic             EXMEM_bubble,
  output logic             MEMWB_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);
  localparam logic       MUL_HOLD = (MUL_LATENCY > 1);

  ctrl_state_t state;
  logic [3:0]  mul_cnt;

  logic mem_wait;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  assign mem_wait = MEM_access & ~MEM_ready;

  assign load_use = EX_MemRead & EX_RegWrite &
                    (src_hazard(ID_uses_rn, reg_idx_t'(ID_Rn), reg_idx_t'(EX_Rd)) |
                     src_hazard(ID_uses_rm, reg_idx_t'(ID_Rm), reg_idx_t'(EX_Rd)));

  // Priority chain: memory wait > multiply hold > branch flush > load-use.
  // A branch seen during a wait is not latched: EX is frozen, so the
  // branch_taken input is still asserted when the wait ends.
  always_comb begin
    PC_write_en    = 1'b1;
    IFID_write_en  = 1'b1;
    IFID_flush     = 1'b0;
    IDEX_write_en  = 1'b1;
    IDEX_bubble    = 1'b0;
    EXMEM_write_en = 1'b1;
    EXMEM_bubble   = 1'b0;
    MEMWB_bubble   = 1'b0;
    flush_inc      = 1'b0;
    if (!reset) begin
      if (mem_wait) begin
        PC_write_en    = 1'b0;
        IFID_write_en  = 1'b0;
        IDEX_write_en  = 1'b0;
        EXMEM_write_en = 1'b0;
        MEMWB_bubble   = 1'b1;
      end else if (state == MUL_BUSY) begin
        PC_write_en   = 1'b0;
        IFID_write_en = 1'b0;
        IDEX_write_en = 1'b0;
        EXMEM_bubble  = 1'b1;
      end else if (EX_branch_taken) begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        PC_write_en   = 1'b0;
        IFID_write_en = 1'b0;
        IDEX_bubble   = 1'b1;
      end
    end
  end

  assign stall_inc = ~PC_write_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else if (!mem_wait) begin
      case (state)
        MUL_BUSY: begin
          mul_cnt <= mul_cnt - 4'd1;
          if (mul_cnt <= 4'd1) begin
            state <= RUN;
          end
        end
        default: begin
          // A multiply issued on a wrong path or behind a load-use stall never enters EX.
          if (MUL_HOLD && ID_is_mul && !EX_branch_taken && !load_use) begin
            state   <= MUL_BUSY;
            mul_cnt <= MUL_INIT;
          end
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors queued at drive
// time and compared on the falling edge; a narrow-counter copy checks saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ID_Rn = '0, ID_Rm = '0, EX_Rd = '0;
  logic       ID_uses_rn = 0, ID_uses_rm = 0, ID_is_mul = 0;
  logic       EX_MemRead = 0, EX_RegWrite = 0, EX_branch_taken = 0;
  logic       MEM_access = 0, MEM_ready = 1;

  logic        PC_write_en, IFID_write_en, IFID_flush, IDEX_write_en, IDEX_bubble;
  logic        EXMEM_write_en, EXMEM_bubble, MEMWB_bubble;
  logic [31:0] stall_count, flush_count;

  logic        s_pc, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_bub, s_exmem_we, s_exmem_bub, s_memwb_bub;
  logic [1:0]  s_stall, s_flush;

  // {PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_bubble, EXMEM_we, EXMEM_bubble, MEMWB_bubble}
  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] MUL = 8'b0000_0110;
  localparam logic [7:0] MW  = 8'b0000_0001;

  logic [7:0] obs;
  assign obs = {PC_write_en, IFID_write_en, IFID_flush, IDEX_write_en, IDEX_bubble,
                EXMEM_write_en, EXMEM_bubble, MEMWB_bubble};

  hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_uses_rn(ID_uses_rn),
    .ID_uses_rm(ID_uses_rm), .ID_is_mul(ID_is_mul), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_branch_taken(EX_branch_taken), .MEM_access(MEM_access),
    .MEM_ready(MEM_ready), .PC_write_en(PC_write_en), .IFID_write_en(IFID_write_en),
    .IFID_flush(IFID_flush), .IDEX_write_en(IDEX_write_en), .IDEX_bubble(IDEX_bubble),
    .EXMEM_write_en(EXMEM_write_en), .EXMEM_bubble(EXMEM_bubble), .MEMWB_bubble(MEMWB_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Same stimulus, no multiply hold and 2-bit counters that saturate quickly.
  hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_uses_rn(ID_uses_rn),
    .ID_uses_rm(ID_uses_rm), .ID_is_mul(ID_is_mul), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_branch_taken(EX_branch_taken), .MEM_access(MEM_access),
    .MEM_ready(MEM_ready), .PC_write_en(s_pc), .IFID_write_en(s_ifid_we),
    .IFID_flush(s_ifid_fl), .IDEX_write_en(s_idex_we), .IDEX_bubble(s_idex_bub),
    .EXMEM_write_en(s_exmem_we), .EXMEM_bubble(s_exmem_bub), .MEMWB_bubble(s_memwb_bub),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 64'(obs), 64'(e));
    end
  end

  task automatic drive(input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                       input logic urm, input logic mul, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic br,
                       input logic ma, input logic mrdy, input logic [7:0] e, input string tag);
    @(posedge clk);
    #1;
    ID_Rn = rn; ID_uses_rn = urn; ID_Rm = rm; ID_uses_rm = urm; ID_is_mul = mul;
    EX_Rd = rd; EX_MemRead = mr; EX_RegWrite = rw; EX_branch_taken = br;
    MEM_access = ma; MEM_ready = mrdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input logic [7:0] e, input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e, tag);
  endtask

  task automatic mul_issue(input string tag);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, DEF, tag);
  endtask

  task automatic mem_wait(input logic br, input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, br, 1, 0, MW, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hazard-producing inputs during reset must not leak to outputs or counters.
    MEM_access = 1; MEM_ready = 0; EX_branch_taken = 1;
    ID_Rn = 5; ID_uses_rn = 1; EX_Rd = 5; EX_MemRead = 1; EX_RegWrite = 1;
    #3;
    chk("rst_outputs", 64'(obs), 64'(DEF));
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_flush", 64'(flush_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_outputs", 64'(obs), 64'(DEF));
    chk("rst_hold_stall", 64'(stall_count), 64'd0);
    chk("rst_hold_flush", 64'(flush_count), 64'd0);
    reset = 0;
    MEM_access = 0; MEM_ready = 1; EX_branch_taken = 0;
    ID_uses_rn = 0; EX_MemRead = 0; EX_RegWrite = 0;

    // Load-use detection
    drive(5, 1, 0, 0, 0, 5, 1, 1, 0, 0, 1, LU, "lu_rn");
    idle(DEF, "lu_after");
    chk("lu_stall1", 64'(stall_count), 64'd1);
    drive(0, 0, 7, 1, 0, 7, 1, 1, 0, 0, 1, LU, "lu_rm");
    drive(5, 1, 0, 0, 0, 6, 1, 1, 0, 0, 1, DEF, "lu_diff_reg");
    chk("lu_stall2", 64'(stall_count), 64'd2);
    drive(5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, DEF, "lu_unused_src");
    drive(31, 1, 31, 1, 0, 31, 1, 1, 0, 0, 1, DEF, "xzr");
    drive(5, 1, 0, 0, 0, 5, 1, 0, 0, 0, 1, DEF, "no_regwrite");
    drive(5, 1, 0, 0, 0, 5, 0, 1, 0, 0, 1, DEF, "no_load");
    idle(DEF, "idle");
    chk("nohaz_stall", 64'(stall_count), 64'd2);

    // Branch beats load-use
    drive(5, 1, 0, 0, 0, 5, 1, 1, 1, 0, 1, BR, "br_over_lu");
    idle(DEF, "br_after");
    chk("br_flush1", 64'(flush_count), 64'd1);
    chk("br_stall", 64'(stall_count), 64'd2);

    // Multiply occupancy
    mul_issue("mul_issue");
    repeat (3) idle(MUL, "mul_busy");
    idle(DEF, "mul_done");
    chk("mul_stall", 64'(stall_count), 64'd5);
    chk("nohold_stall", 64'(s_stall), 64'd2);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, BR, "br_kills_mul");
    idle(DEF, "br_mul_after");
    chk("br_mul_flush", 64'(flush_count), 64'd2);

    // Memory wait inside a multiply stretches MUL_BUSY
    mul_issue("mw_mul_issue");
    idle(MUL, "mw_mul_busy0");
    mem_wait(0, "mw_in_mul0");
    mem_wait(0, "mw_in_mul1");
    idle(MUL, "mw_mul_busy1");
    idle(MUL, "mw_mul_busy2");
    idle(DEF, "mw_mul_done");
    chk("mw_mul_stall", 64'(stall_count), 64'd10);
    chk("sat_stall", 64'(s_stall), 64'd3);

    // Branch pending across a wait
    mem_wait(1, "br_wait0");
    mem_wait(1, "br_wait1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR, "br_release");
    idle(DEF, "br_release_after");
    chk("br_wait_flush", 64'(flush_count), 64'd3);
    chk("br_wait_stall", 64'(stall_count), 64'd12);

    // Branch and load-use ignored while EX holds a multiply
    mul_issue("ign_mul_issue");
    drive(5, 1, 0, 0, 0, 5, 1, 1, 1, 0, 1, MUL, "mul_ignores_br");
    idle(MUL, "ign_busy1");
    idle(MUL, "ign_busy2");
    idle(DEF, "ign_done");
    chk("ign_stall", 64'(stall_count), 64'd15);
    chk("ign_flush", 64'(flush_count), 64'd3);
    chk("sat_flush", 64'(s_flush), 64'd3);
    chk("sat_stall_hold", 64'(s_stall), 64'd3);

    // Asynchronous reset in the middle of MUL_BUSY
    mul_issue("rst_mul_issue");
    idle(MUL, "rst_mul_busy");
    @(negedge clk);
    #1;
    reset = 1;
    #1;
    chk("async_rst_outputs", 64'(obs), 64'(DEF));
    chk("async_rst_stall", 64'(stall_count), 64'd0);
    chk("async_rst_flush", 64'(flush_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 0;
    drive(5, 1, 0, 0, 0, 5, 1, 1, 0, 0, 1, LU, "post_rst_lu");
    idle(DEF, "post_rst_idle");
    chk("post_rst_stall", 64'(stall_count), 64'd1);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
